// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared state encoding and trigger mode constants for the ADC capture controller.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_PREFILL = 2'd0,
        ST_ARMED   = 2'd1,
        ST_POST    = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    localparam logic [2:0] TRIG_AUTO   = 3'd0;
    localparam logic [2:0] TRIG_RISE   = 3'd1;
    localparam logic [2:0] TRIG_FALL   = 3'd2;
    localparam logic [2:0] TRIG_EITHER = 3'd3;
    localparam logic [2:0] TRIG_MANUAL = 3'd4;

endpackage

// File: rtl/sample_strobe_gen.sv
// sample_strobe_gen: divider counter producing the RAM write / sample strobe.
module sample_strobe_gen #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] sample_divider,
    input  logic             hold,
    output logic             mem_en
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // >= so that lowering the divider mid-count fires on the next clk instead of wrapping
    assign mem_en = (cnt_q >= sample_divider) & ~hold & rst_n;
    assign cnt_d  = (hold | mem_en) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: circular pre-trigger capture into one bank of a double-banked sample RAM.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DIV_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  sample_divider,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic [2:0]        trigger_mode,
    input  logic              trigger_req,
    input  logic              rising_edge,
    input  logic              falling_edge,
    input  logic              update_en,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_en,
    output logic              triggered,
    output logic              armed,
    output logic              done_flag,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr
);
    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic              bank_q, bank_d;
    logic              done_q, done_d;
    logic              load_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] trig_q, trig_d;
    logic [ADDR_W-1:0] pre_q, pre_cur;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc, post_len;
    logic              strobe, fire;

    // The done cycle is also gated so the first write to the new bank lands 1 + divider clks later
    sample_strobe_gen #(.DIV_W(DIV_W)) u_strobe (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_divider (sample_divider),
        .hold           ((state_q == ST_HOLD) | done_q),
        .mem_en         (strobe)
    );

    assign pre_cur  = load_q ? pretrig_len : pre_q;
    assign cnt_inc  = cnt_q + {{ADDR_W{1'b0}}, strobe};
    assign post_len = (ADDR_W+1)'(DEPTH) - {1'b0, pre_q};
    assign addr_d   = addr_q + {{(ADDR_W-1){1'b0}}, strobe};
    assign fire     = trigger_req
                    | (trigger_mode == TRIG_AUTO)
                    | (trigger_mode == TRIG_RISE & rising_edge)
                    | (trigger_mode == TRIG_FALL & falling_edge)
                    | (trigger_mode == TRIG_EITHER & (rising_edge | falling_edge));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PREFILL;
            bank_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b1;
            addr_q  <= '0;
            trig_q  <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
            load_q  <= done_d;
            addr_q  <= addr_d;
            trig_q  <= trig_d;
            pre_q   <= pre_cur;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        trig_d  = trig_q;
        cnt_d   = cnt_inc;
        case (state_q)
            ST_PREFILL: begin
                if (cnt_inc >= {1'b0, pre_cur}) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end
            end
            ST_ARMED: begin
                cnt_d = '0;
                if (fire) begin
                    trig_d  = addr_q;
                    cnt_d   = {{ADDR_W{1'b0}}, strobe};
                    // A one-sample post record already completed by the trigger-cycle strobe skips POST
                    state_d = (cnt_d >= post_len) ? ST_HOLD : ST_POST;
                end
            end
            ST_POST: begin
                if (cnt_inc >= post_len) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
                if (update_en) begin
                    state_d = ST_PREFILL;
                    bank_d  = ~bank_q;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        mem_en     = strobe;
        mem_addr   = {bank_q, addr_q};
        triggered  = (state_q == ST_POST);
        armed      = (state_q == ST_ARMED);
        done_flag  = done_q;
        trig_addr  = trig_q;
        start_addr = trig_q - pre_q;
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: scoreboard bench for the pre-trigger capture controller at ADDR_W=4.
module tb_adc_capture_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sample_divider = '0;
    logic [AW-1:0] pretrig_len = '0;
    logic [2:0]    trigger_mode = '0;
    logic          trigger_req = 1'b0;
    logic          rising_edge = 1'b0;
    logic          falling_edge = 1'b0;
    logic          update_en = 1'b0;
    logic [AW:0]   mem_addr;
    logic          mem_en, triggered, armed, done_flag;
    logic [AW-1:0] trig_addr, start_addr;

    int          checks = 0;
    int          failures = 0;
    logic [AW:0] sb[$];
    logic [AW:0] sb_e;

    always #5 clk = ~clk;

    adc_capture_ctrl #(.ADDR_W(AW), .DIV_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_divider (sample_divider),
        .pretrig_len    (pretrig_len),
        .trigger_mode   (trigger_mode),
        .trigger_req    (trigger_req),
        .rising_edge    (rising_edge),
        .falling_edge   (falling_edge),
        .update_en      (update_en),
        .mem_addr       (mem_addr),
        .mem_en         (mem_en),
        .triggered      (triggered),
        .armed          (armed),
        .done_flag      (done_flag),
        .trig_addr      (trig_addr),
        .start_addr     (start_addr)
    );

    // Every write strobe must match the next expected address in the scoreboard
    always @(negedge clk) begin
        #2;
        if (rst_n && mem_en) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_write unexpected write addr=%h, none expected", mem_addr);
            end else begin
                sb_e = sb.pop_front();
                if (mem_addr !== sb_e) begin
                    failures++;
                    $display("FAIL sb_write addr=%h expected=%h", mem_addr, sb_e);
                end
            end
        end
    end

    task automatic do_reset(input logic [DW-1:0] div, input logic [AW-1:0] pre, input logic [2:0] mode);
        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d expected 0", sb.size());
        end
        sb.delete();
        rst_n = 1'b0;
        sample_divider = div;
        pretrig_len = pre;
        trigger_mode = mode;
        trigger_req = 1'b0;
        rising_edge = 1'b0;
        falling_edge = 1'b0;
        update_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_en, mem_addr, triggered, armed, done_flag, trig_addr, start_addr} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected 0",
                     {mem_en, mem_addr, triggered, armed, done_flag, trig_addr, start_addr});
        end
    endtask

    task automatic test_auto;
        int n, post;
        do_reset(8'd0, 4'd5, 3'd0);
        for (int i = 0; i < 16; i++) sb.push_back((AW+1)'(i));
        rst_n = 1'b1;
        n = 0;
        while (!armed && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != 5) begin failures++; $display("FAIL auto_prefill_clks got=%0d expected 5", n); end
        post = mem_en ? 1 : 0;
        @(negedge clk);
        checks++;
        if (trig_addr !== 4'd5) begin failures++; $display("FAIL auto_trig_addr got=%0d expected 5", trig_addr); end
        while (triggered && n < 200) begin if (mem_en) post++; @(negedge clk); n++; end
        checks++;
        if (post != 11) begin failures++; $display("FAIL auto_post_writes got=%0d expected 11", post); end
        checks++;
        if (start_addr !== 4'd0) begin failures++; $display("FAIL auto_start_addr got=%0d expected 0", start_addr); end
        checks++;
        if ({mem_en, mem_addr} !== 6'd0) begin failures++; $display("FAIL auto_hold_addr got=%h expected 0", {mem_en, mem_addr}); end
    endtask

    task automatic test_edge;
        int n, post;
        do_reset(8'd3, 4'd4, 3'd1);
        for (int i = 0; i < 21; i++) sb.push_back((AW+1)'(i % 16));
        rst_n = 1'b1;
        n = 0;
        while (!armed && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (n != 16) begin failures++; $display("FAIL edge_prefill_clks got=%0d expected 16", n); end
        falling_edge = 1'b1;
        n = 0;
        while (!(mem_en && mem_addr[AW-1:0] == 4'd9) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!(armed && mem_en)) begin failures++; $display("FAIL edge_align armed=%b mem_en=%b expected 1 1", armed, mem_en); end
        rising_edge = 1'b1;
        post = mem_en ? 1 : 0;
        @(negedge clk);
        rising_edge = 1'b0;
        falling_edge = 1'b0;
        checks++;
        if (triggered !== 1'b1 || trig_addr !== 4'd9) begin
            failures++;
            $display("FAIL edge_trig triggered=%b trig_addr=%0d expected 1 9", triggered, trig_addr);
        end
        n = 0;
        while (triggered && n < 200) begin if (mem_en) post++; @(negedge clk); n++; end
        checks++;
        if (post != 12) begin failures++; $display("FAIL edge_post_writes got=%0d expected 12", post); end
        checks++;
        if (start_addr !== 4'd5 || mem_addr !== 5'd5) begin
            failures++;
            $display("FAIL edge_hold start_addr=%0d mem_addr=%0d expected 5 5", start_addr, mem_addr);
        end
    endtask

    task automatic test_manual;
        int n, post;
        do_reset(8'd0, 4'd3, 3'd4);
        for (int i = 0; i < 22; i++) sb.push_back((AW+1)'(i % 16));
        rising_edge = 1'b1;
        falling_edge = 1'b1;
        rst_n = 1'b1;
        n = 0;
        while (!armed && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != 3) begin failures++; $display("FAIL manual_prefill_clks got=%0d expected 3", n); end
        repeat (6) @(negedge clk);
        checks++;
        if (armed !== 1'b1) begin failures++; $display("FAIL manual_edges_ignored armed=%b expected 1", armed); end
        trigger_req = 1'b1;
        post = mem_en ? 1 : 0;
        @(negedge clk);
        trigger_req = 1'b0;
        checks++;
        if (triggered !== 1'b1 || trig_addr !== 4'd9) begin
            failures++;
            $display("FAIL manual_trig triggered=%b trig_addr=%0d expected 1 9", triggered, trig_addr);
        end
        n = 0;
        while (triggered && n < 200) begin if (mem_en) post++; @(negedge clk); n++; end
        rising_edge = 1'b0;
        falling_edge = 1'b0;
        checks++;
        if (post != 13) begin failures++; $display("FAIL manual_post_writes got=%0d expected 13", post); end
        checks++;
        if (start_addr !== 4'd6 || mem_addr !== 5'd6) begin
            failures++;
            $display("FAIL manual_hold start_addr=%0d mem_addr=%0d expected 6 6", start_addr, mem_addr);
        end
    endtask

    task automatic test_hold;
        int n;
        n = 0;
        repeat (100) begin if (mem_en) n++; @(negedge clk); end
        checks++;
        if (n != 0 || mem_addr !== 5'd6) begin
            failures++;
            $display("FAIL hold_no_write strobes=%0d mem_addr=%0d expected 0 6", n, mem_addr);
        end
        update_en = 1'b1;
        @(negedge clk);
        update_en = 1'b0;
        sb.push_back(5'h16);
        checks++;
        if (done_flag !== 1'b1 || mem_addr !== 5'h16 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL hold_swap done=%b mem_addr=%h mem_en=%b expected 1 16 0", done_flag, mem_addr, mem_en);
        end
        checks++;
        if (trig_addr !== 4'd9 || start_addr !== 4'd6) begin
            failures++;
            $display("FAIL hold_stable trig=%0d start=%0d expected 9 6", trig_addr, start_addr);
        end
        @(negedge clk);
        checks++;
        if (done_flag !== 1'b0 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL hold_after_swap done=%b mem_en=%b expected 0 1", done_flag, mem_en);
        end
    endtask

    task automatic test_pretrig_bounds;
        logic [AW-1:0] pre_t[2]   = '{4'd0, 4'd15};
        logic [AW-1:0] trig_t[2]  = '{4'd1, 4'd15};
        logic [AW-1:0] start_t[2] = '{4'd1, 4'd0};
        int            pfx_t[2]   = '{1, 15};
        int            post_t[2]  = '{16, 1};
        int            wr_t[2]    = '{17, 16};
        int            n, post;
        for (int k = 0; k < 2; k++) begin
            do_reset(8'd0, pre_t[k], 3'd0);
            for (int i = 0; i < wr_t[k]; i++) sb.push_back((AW+1)'(i % 16));
            rst_n = 1'b1;
            n = 0;
            while (!armed && n < 100) begin @(negedge clk); n++; end
            checks++;
            if (n != pfx_t[k]) begin failures++; $display("FAIL bounds%0d_prefill got=%0d expected %0d", k, n, pfx_t[k]); end
            post = mem_en ? 1 : 0;
            @(negedge clk);
            while (triggered && n < 200) begin if (mem_en) post++; @(negedge clk); n++; end
            checks++;
            if (post != post_t[k]) begin failures++; $display("FAIL bounds%0d_post got=%0d expected %0d", k, post, post_t[k]); end
            checks++;
            if (trig_addr !== trig_t[k] || start_addr !== start_t[k]) begin
                failures++;
                $display("FAIL bounds%0d_addr trig=%0d start=%0d expected %0d %0d",
                         k, trig_addr, start_addr, trig_t[k], start_t[k]);
            end
            checks++;
            if (armed !== 1'b0 || mem_addr !== {1'b0, start_t[k]}) begin
                failures++;
                $display("FAIL bounds%0d_hold armed=%b mem_addr=%0d expected 0 %0d", k, armed, mem_addr, start_t[k]);
            end
        end
    endtask

    task automatic test_async_reset;
        int n, d;
        do_reset(8'd0, 4'd5, 3'd0);
        for (int i = 0; i < 7; i++) sb.push_back((AW+1)'(i));
        rst_n = 1'b1;
        n = 0;
        while (!triggered && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != 6) begin failures++; $display("FAIL async_reach_post got=%0d expected 6", n); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_addr, triggered, armed, done_flag, trig_addr, start_addr} !== 17'd0) begin
            failures++;
            $display("FAIL async_outputs got=%h expected 0",
                     {mem_en, mem_addr, triggered, armed, done_flag, trig_addr, start_addr});
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) sb.push_back((AW+1)'(i));
        rst_n = 1'b1;
        checks++;
        if (armed !== 1'b0 || triggered !== 1'b0 || mem_addr !== 5'd0) begin
            failures++;
            $display("FAIL async_restart armed=%b triggered=%b mem_addr=%h expected 0 0 0", armed, triggered, mem_addr);
        end
        d = 0;
        for (int i = 0; i < 3; i++) begin
            d += int'(done_flag);
            if (i < 2) @(negedge clk);
        end
        checks++;
        if (d != 0) begin failures++; $display("FAIL async_no_done got=%0d expected 0", d); end
    endtask

    initial begin
        test_reset;
        test_auto;
        test_edge;
        test_manual;
        test_hold;
        test_pretrig_bounds;
        test_async_reset;
        do_reset(8'd0, 4'd0, 3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
